dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the MEM stage's data accesses. Accepts one load/store request at a time over a valid/ready handshake.
- Performs RV32I byte/half/word accesses on an internal word-addressed RAM, with load sign/zero extension and store byte-lane masking.
- Returns a response after a parameterised number of wait states, so the MEM stage can be exercised against non-ideal memory latency.
- Single outstanding transaction; the MEM stage stalls while req_ready is low.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits
WAIT_STATES, 1, extra cycles between request accept and access/response (0..15)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extend (LBU/LHU) when 1, sign-extend when 0
rsp_valid  output  1  response present
rsp_ready  input  1  requester takes response
rsp_rdata  output  32  load result, extended; 0 for stores and errors
rsp_err  output  1  misaligned or illegal-size request

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Any in-flight request is discarded; a store not yet performed never reaches RAM. RAM contents are not reset.
- FSM IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture we/addr/wdata/size/unsigned.
  - If error: go to RESP next edge, no wait states.
  - Else if WAIT_STATES=0: perform access at the accept edge and go to RESP.
  - Else: load counter=WAIT_STATES-1 and go to WAIT.
- FSM WAIT:
  - req_ready=0.
  - When counter=0: perform access on that edge, go to RESP.
  - Otherwise decrement the counter.
- FSM RESP:
  - req_ready=0, rsp_valid=1. rsp_rdata/rsp_err held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: go to IDLE; rsp_valid=0 next cycle.
- Latency: if accept occurs on edge T, rsp_valid is high from the cycle after edge T+WAIT_STATES. Error responses appear the cycle after edge T regardless of WAIT_STATES.
- Throughput: at most one request per WAIT_STATES+2 cycles; back-to-back requests wait in IDLE.
- Address mapping: word index = req_addr[ADDR_WIDTH+1:2]. Upper bits are ignored (aliasing wrap, no error). Byte offset = req_addr[1:0].
- Error conditions:
  - size=11
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]!=00
  - On error: no RAM write, rsp_err=1, rsp_rdata=0.
- Store:
  - Byte: wdata[7:0] written to lane addr[1:0].
  - Half: wdata[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all lanes written.
  - Unselected lanes are unchanged. Response has rsp_rdata=0, rsp_err=0.
- Load:
  - Read the addressed word at the access edge and extract the byte/half at the offset.
  - Extend to 32 bits: sign bit = bit 7/15 of the extracted value when req_unsigned=0, else zero.
  - Word loads pass through unchanged.
- Load after store to the same address (separate transactions) returns the new data.
- Requester must hold request signals only until accepted; the captured copy is used thereafter. Request inputs changing during WAIT/RESP have no effect.
- rsp_ready high while not in RESP has no effect.

Test Plan:
- Reset: drive rst=0 mid-WAIT of a SW 0xDEADBEEF to addr 0x10, release, then LW 0x10 -> rsp_rdata=0x00000000 (store discarded; RAM preloaded to 0); req_ready=1 and rsp_valid=0 during reset.
- Word store/load, WAIT_STATES=1:
  - SW 0x12345678 @0x20 -> ack rsp_valid 2 cycles after accept, rsp_err=0.
  - LW @0x20 -> 0x12345678.
- Byte/half lanes: after the word store above:
  - SB 0xAB @0x21, then LW @0x20 -> 0x1234AB78.
  - LB @0x21 -> 0xFFFFFFAB; LBU @0x21 -> 0x000000AB.
  - SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001.
- Misalignment: LW @0x22 and SH @0x23 -> rsp_err=1, rsp_rdata=0, response 1 cycle after accept, RAM word @0x20 unchanged; size=11 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load response -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, and a new req_valid is not accepted until the cycle after rsp_ready=1.
- Wrap: with ADDR_WIDTH=10, SW 0xCAFEF00D @0x00001004, then LW @0x00000004 -> 0xCAFEF00D; repeat with WAIT_STATES=0 -> response the cycle after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for MEM-stage data accesses. Accepts one RV32I
//   load/store at a time over a valid/ready handshake. The access goes to an
//   internal word-addressed RAM after WAIT_STATES extra cycles, and a response
//   is returned over a second valid/ready handshake.
//
// Ports
//   clk, rst           clock (rising edge); asynchronous active-low reset
//   req_valid/ready    request handshake (ready is high only in IDLE)
//   req_we             1 = store, 0 = load
//   req_addr           byte address; bits above ADDR_WIDTH+1 alias
//   req_wdata          right-aligned store data
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       zero-extend loads when 1, sign-extend when 0
//   rsp_valid/ready    response handshake
//   rsp_rdata          extended load data; 0 for stores and errors
//   rsp_err            misaligned or illegal-size request
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;

  logic [31:0] mem [DEPTH];

  // Upper address bits only alias; they are intentionally not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Access operands: live request while in IDLE (zero-wait access happens on
  // the accept edge), captured copy otherwise.
  logic                  acc_we;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [1:0]            acc_size;
  logic                  acc_uns;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [1:0]            acc_off;

  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr[ADDR_WIDTH+1:0];
      acc_wdata = req_wdata;
      acc_size  = req_size;
      acc_uns   = req_unsigned;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
    end
  end

  assign acc_idx = acc_addr[ADDR_WIDTH+1:2];
  assign acc_off = acc_addr[1:0];

  always_comb begin
    case (acc_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = acc_off[0];
      2'b10:   acc_err = (acc_off != 2'b00);
      default: acc_err = 1'b1;
    endcase
  end

  // Load extraction and extension
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign rd_word = mem[acc_idx];
  assign rd_half = acc_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (acc_off)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    case (acc_size)
      2'b00:   load_data = {{24{~acc_uns & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~acc_uns & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // Store lane enables and lane-replicated data
  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    case (acc_size)
      2'b00: begin
        st_be   = 4'b0001 << acc_off;
        st_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = acc_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = acc_wdata;
      end
    endcase
  end

  logic do_access;
  logic mem_we;

  assign mem_we = do_access & acc_we;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    do_access   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr[ADDR_WIDTH+1:0];
          wdata_d     = req_wdata;
          size_d      = req_size;
          uns_d       = req_unsigned;
          req_ready_d = 1'b0;
          if (acc_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (WAIT_STATES == 0) begin
            do_access   = 1'b1;
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = acc_we ? '0 : load_data;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access   = 1'b1;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = acc_we ? '0 : load_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  // RAM is not reset; an async reset returns the FSM to IDLE before any
  // pending access edge, so a discarded store never writes.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (mem_we && st_be[i]) begin
        mem[acc_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_ready;

  logic        rv0, rv1;
  logic        rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0] rd0, rd1;

  logic        dut_rdy, dut_vld, dut_err;
  logic [31:0] dut_rd;

  int n_assert;
  int n_fail;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb[$];

  assign rv0     = req_valid & ~sel;
  assign rv1     = req_valid & sel;
  assign dut_rdy = sel ? rdy1 : rdy0;
  assign dut_vld = sel ? vld1 : vld0;
  assign dut_err = sel ? err1 : err0;
  assign dut_rd  = sel ? rd1  : rd0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .rst(rst),
    .req_valid(rv0), .req_ready(rdy0), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(vld0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err0)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst),
    .req_valid(rv1), .req_ready(rdy1), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction: push expectation, drive until accepted, scramble the
  // request inputs, wait for the response, pop and compare, optionally hold
  // off rsp_ready for 'hold' cycles while a competing request is presented.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                     input int hold);
    exp_t e;
    int   cyc;
    e.d = exp_d; e.e = exp_e; e.lat = exp_lat;
    sb.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_size = size; req_unsigned = uns;
    cyc = 0;
    while (!dut_rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_accept"}, 32'(dut_rdy), 32'd1);

    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = addr ^ 32'h0000_0004;
    req_wdata = ~wdata; req_size = ~size; req_unsigned = ~uns;
    cyc = 1;
    while (!dut_vld && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end

    e = sb.pop_front();
    check({tag, "_lat"},   cyc, e.lat);
    check({tag, "_rdata"}, dut_rd, e.d);
    check({tag, "_err"},   32'(dut_err), 32'(e.e));
    check({tag, "_rdy_busy"}, 32'(dut_rdy), 32'd0);

    if (hold > 0) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
      req_wdata = 32'h5555_5555; req_size = 2'b10; req_unsigned = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_vld"},   32'(dut_vld), 32'd1);
        check({tag, "_hold_rdata"}, dut_rd, e.d);
        check({tag, "_hold_rdy"},   32'(dut_rdy), 32'd0);
      end
      req_valid = 1'b0;
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_vld_drop"}, 32'(dut_vld), 32'd0);
    check({tag, "_rdy_back"}, 32'(dut_rdy), 32'd1);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    sel = 1'b0; rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b10; req_unsigned = 1'b0; rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_rdy",   32'(dut_rdy), 32'd1);
    check("reset_vld",   32'(dut_vld), 32'd0);
    check("reset_rdata", dut_rd, 32'd0);
    check("reset_err",   32'(dut_err), 32'd0);
    rst = 1'b1;

    // Known contents at 0x10, then a store aborted mid-WAIT by reset
    txn("sw_zero", 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 2, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
    req_wdata = 32'hDEAD_BEEF; req_size = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_wait", 32'(dut_rdy), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_rst_rdy", 32'(dut_rdy), 32'd1);
    check("abort_rst_vld", 32'(dut_vld), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    txn("lw_after_abort", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 2, 0);

    // Word, byte and half accesses with one wait state
    txn("sw_20",  1'b1, 32'h20, 32'h1234_5678, 2'b10, 1'b0, 32'h0,         1'b0, 2, 0);
    txn("lw_20",  1'b0, 32'h20, 32'h0,         2'b10, 1'b0, 32'h1234_5678, 1'b0, 2, 0);
    txn("sb_21",  1'b1, 32'h21, 32'h0000_00AB, 2'b00, 1'b0, 32'h0,         1'b0, 2, 0);
    txn("lw_20b", 1'b0, 32'h20, 32'h0,         2'b10, 1'b0, 32'h1234_AB78, 1'b0, 2, 0);
    txn("lb_21",  1'b0, 32'h21, 32'h0,         2'b00, 1'b0, 32'hFFFF_FFAB, 1'b0, 2, 0);
    txn("lbu_21", 1'b0, 32'h21, 32'h0,         2'b00, 1'b1, 32'h0000_00AB, 1'b0, 2, 0);
    txn("sh_22",  1'b1, 32'h22, 32'h0000_8001, 2'b01, 1'b0, 32'h0,         1'b0, 2, 0);
    txn("lh_22",  1'b0, 32'h22, 32'h0,         2'b01, 1'b0, 32'hFFFF_8001, 1'b0, 2, 0);
    txn("lhu_22", 1'b0, 32'h22, 32'h0,         2'b01, 1'b1, 32'h0000_8001, 1'b0, 2, 0);

    // Errors respond one cycle after accept and leave RAM untouched
    txn("lw_mis",  1'b0, 32'h22, 32'h0,         2'b10, 1'b0, 32'h0, 1'b1, 1, 0);
    txn("sh_mis",  1'b1, 32'h23, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0, 1'b1, 1, 0);
    txn("sz_ill",  1'b1, 32'h20, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h0, 1'b1, 1, 0);
    txn("lw_keep", 1'b0, 32'h20, 32'h0,         2'b10, 1'b0, 32'h8001_AB78, 1'b0, 2, 0);

    // Backpressure with a competing request presented during RESP
    txn("lb_hold", 1'b0, 32'h20, 32'h0, 2'b00, 1'b0, 32'h0000_0078, 1'b0, 2, 5);
    txn("lw_post", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h8001_AB78, 1'b0, 2, 0);

    // Address aliasing above ADDR_WIDTH
    txn("sw_wrap", 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,         1'b0, 2, 0);
    txn("lw_wrap", 1'b0, 32'h0000_0004, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 2, 0);

    // Zero wait states
    sel = 1'b1;
    @(negedge clk);
    txn("ws0_sw",  1'b1, 32'h0000_1004, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,         1'b0, 1, 0);
    txn("ws0_lw",  1'b0, 32'h0000_0004, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1, 0);
    txn("ws0_lh",  1'b0, 32'h0000_1006, 32'h0,         2'b01, 1'b0, 32'hFFFF_CAFE, 1'b0, 1, 0);
    txn("ws0_err", 1'b0, 32'h0000_0005, 32'h0,         2'b01, 1'b0, 32'h0,         1'b1, 1, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
